// File: rtl/cpu_pkg.sv
// Shared CPU types and defaults for the register file and its read ports.
// No logic, no latency.
// No flow control; constants and types only.
package cpu_pkg;

  localparam int RF_DATA_W    = 32;
  localparam int RF_ADDR_W    = 5;
  localparam int RF_ZERO_ADDR = 0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: zero mask, write-to-read bypass, output register.
// Latency 1 cycle from rd_en to rd_data.
// No backpressure; rd_data holds its value while rd_en is low.
module rf_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clearing,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              wr_act,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  import cpu_pkg::*;

  logic              is_zero;
  logic              wr_hit;
  logic [DATA_W-1:0] next_val;

  // Register 0 is masked even when a write to it would otherwise be forwarded.
  assign is_zero = (ZERO_REG != 0) && (rd_addr == ADDR_W'(RF_ZERO_ADDR));
  assign wr_hit  = (BYPASS != 0) && wr_act && (wr_addr == rd_addr);

  // Select the value captured this edge: clear/zero first, then bypass, then storage.
  always_comb begin
    next_val = reg_val;
    if (clearing || is_zero) begin
      next_val = '0;
    end else if (wr_hit) begin
      next_val = wr_data;
    end
  end

  // Output register: cleared on reset, updated only on a read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= next_val;
    end
  end

endmodule

// File: rtl/pipeline_regfile.sv
// Multi-read, single-write register file with a post-reset clear sequence.
// Reads: 1-cycle latency; writes land at the edge; clear takes DEPTH cycles.
// No backpressure; ready stays low and writes are ignored until the clear finishes.
module pipeline_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic                     wr_dst_sel,
  input  logic [ADDR_W-1:0]        wr_addr_rd,
  input  logic [ADDR_W-1:0]        wr_addr_rt,
  input  logic [DATA_W-1:0]        wr_data
);

  localparam int DEPTH = 1 << ADDR_W;
  // Counter is one bit wider than an address so the last-entry compare never wraps.
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);

  logic [DATA_W-1:0] regs [DEPTH];
  rf_state_t         state;
  logic [ADDR_W:0]   clr_cnt;
  logic [ADDR_W-1:0] waddr;
  logic              clearing;
  logic              wr_act;
  logic              wr_drop;

  assign clearing = (state == RF_CLEAR);
  assign ready    = (state == RF_RUN);
  assign waddr    = wr_dst_sel ? wr_addr_rd : wr_addr_rt;
  assign wr_act   = wr_en && !clearing;
  assign wr_drop  = (ZERO_REG != 0) && (waddr == ADDR_W'(RF_ZERO_ADDR));

  // Clear sequencer: walk every entry once after reset, then hand over to normal operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      clr_cnt <= '0;
    end else if (clearing) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == CLR_LAST) begin
        state <= RF_RUN;
      end
    end
  end

  // Storage: zero-fill during the clear sequence, otherwise take the single write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clearing) begin
        regs[clr_cnt[ADDR_W-1:0]] <= '0;
      end else if (wr_en && !wr_drop) begin
        regs[waddr] <= wr_data;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] reg_val_i;

    assign addr_i    = rd_addr[i*ADDR_W +: ADDR_W];
    assign reg_val_i = regs[addr_i];

    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
      .clearing (clearing),
      .rd_en    (rd_en[i]),
      .rd_addr  (addr_i),
      .reg_val  (reg_val_i),
      .wr_act   (wr_act),
      .wr_addr  (waddr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_pipeline_regfile.sv
// Directed bench for two register-file configurations sharing one clock and reset.
// A: defaults (32x32, 2 ports, zero reg, bypass). B: 16x16, 3 ports, no zero reg, no bypass.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_pipeline_regfile;

  logic clk;
  logic rst;

  // Instance A
  logic        ready;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        wr_en;
  logic        wr_dst_sel;
  logic [4:0]  wr_addr_rd;
  logic [4:0]  wr_addr_rt;
  logic [31:0] wr_data;

  // Instance B
  logic        ready_b;
  logic [2:0]  rd_en_b;
  logic [11:0] rd_addr_b;
  logic [47:0] rd_data_b;
  logic        wr_en_b;
  logic        wr_dst_sel_b;
  logic [3:0]  wr_addr_rd_b;
  logic [3:0]  wr_addr_rt_b;
  logic [15:0] wr_data_b;

  int vectors = 0;
  int errs    = 0;

  pipeline_regfile u_dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_dst_sel (wr_dst_sel),
    .wr_addr_rd (wr_addr_rd),
    .wr_addr_rt (wr_addr_rt),
    .wr_data    (wr_data)
  );

  pipeline_regfile #(
    .DATA_W   (16),
    .ADDR_W   (4),
    .NUM_RD   (3),
    .ZERO_REG (0),
    .BYPASS   (0)
  ) u_alt (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready_b),
    .rd_en      (rd_en_b),
    .rd_addr    (rd_addr_b),
    .rd_data    (rd_data_b),
    .wr_en      (wr_en_b),
    .wr_dst_sel (wr_dst_sel_b),
    .wr_addr_rd (wr_addr_rd_b),
    .wr_addr_rt (wr_addr_rt_b),
    .wr_data    (wr_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    rd_en   = '0;
    wr_en_b = 1'b0;
    rd_en_b = '0;
  endtask

  // A: R-type write (dst_sel=1); rt points elsewhere so a wrong mux is visible.
  task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
    wr_en      = 1'b1;
    wr_dst_sel = 1'b1;
    wr_addr_rd = a;
    wr_addr_rt = ~a;
    wr_data    = d;
  endtask

  task automatic rd_set_a(input int p, input logic [4:0] a);
    rd_en[p]          = 1'b1;
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic rd_set_b(input int p, input logic [3:0] a);
    rd_en_b[p]          = 1'b1;
    rd_addr_b[p*4 +: 4] = a;
  endtask

  function automatic logic [31:0] rd_a(input int p);
    return rd_data[p*32 +: 32];
  endfunction

  function automatic logic [31:0] rd_b(input int p);
    return {16'h0, rd_data_b[p*16 +: 16]};
  endfunction

  initial begin
    int na;
    int nb;
    int n;

    rst = 1'b1;
    idle();
    wr_dst_sel = 1'b0; wr_addr_rd = '0; wr_addr_rt = '0; wr_data = '0; rd_addr = '0;
    wr_dst_sel_b = 1'b0; wr_addr_rd_b = '0; wr_addr_rt_b = '0; wr_data_b = '0; rd_addr_b = '0;

    // ---- Clear after reset: A takes 32 cycles, B takes 16 ----
    tick();
    chk("rst_ready_a", {31'b0, ready}, 32'h0);
    chk("rst_rd0_a", rd_a(0), 32'h0);
    chk("rst_rd1_a", rd_a(1), 32'h0);
    chk("rst_rd2_b", rd_b(2), 32'h0);
    rst = 1'b0;
    na = 0;
    nb = 0;
    while ((!ready || !ready_b) && na < 200) begin
      if (!ready)   na++;
      if (!ready_b) nb++;
      tick();
    end
    chk("clear_len_a", na, 32);
    chk("clear_len_b", nb, 16);

    for (int a = 0; a < 32; a++) begin
      idle();
      rd_set_a(0, 5'(a));
      rd_set_a(1, 5'(31 - a));
      rd_set_b(a % 3, 4'(a));
      tick();
      chk("clear_rd0_a", rd_a(0), 32'h0);
      chk("clear_rd1_a", rd_a(1), 32'h0);
      chk("clear_rd_b", rd_b(a % 3), 32'h0);
    end

    // ---- Basic write/read, dst mux, port hold ----
    idle();
    wr_en = 1'b1; wr_dst_sel = 1'b0; wr_addr_rt = 5'd6; wr_addr_rd = 5'd12; wr_data = 32'hA5A5A5A5;
    tick();
    idle(); rd_set_a(1, 5'd6); tick();
    chk("rt_write_r6", rd_a(1), 32'hA5A5A5A5);
    idle(); wr_a(5'd5, 32'hDEADBEEF); tick();
    idle(); rd_set_a(0, 5'd5); tick();
    chk("rd_write_r5", rd_a(0), 32'hDEADBEEF);
    chk("hold_port1", rd_a(1), 32'hA5A5A5A5);
    idle(); rd_set_a(0, 5'd12); rd_set_a(1, 5'd26); tick();
    chk("unsel_rd_r12", rd_a(0), 32'h0);
    chk("unsel_rt_r26", rd_a(1), 32'h0);

    // ---- Bypass (A) ----
    idle(); wr_a(5'd7, 32'h11111111); tick();
    idle(); wr_a(5'd7, 32'h12345678); rd_set_a(0, 5'd7); rd_set_a(1, 5'd7); tick();
    chk("bypass_p0", rd_a(0), 32'h12345678);
    chk("bypass_p1", rd_a(1), 32'h12345678);
    idle(); wr_a(5'd3, 32'h33333333); rd_set_a(0, 5'd7); rd_set_a(1, 5'd5); tick();
    chk("after_bypass_r7", rd_a(0), 32'h12345678);
    chk("no_hit_r5", rd_a(1), 32'hDEADBEEF);

    // ---- Zero register (A) ----
    idle();
    wr_en = 1'b1; wr_dst_sel = 1'b0; wr_addr_rt = 5'd0; wr_addr_rd = 5'd7; wr_data = 32'hFFFFFFFF;
    rd_set_a(0, 5'd0); rd_set_a(1, 5'd7);
    tick();
    chk("zero_same_cycle", rd_a(0), 32'h0);
    chk("zero_rd_field_unused", rd_a(1), 32'h12345678);
    idle(); rd_set_a(0, 5'd0); rd_set_a(1, 5'd0); tick();
    chk("zero_after_p0", rd_a(0), 32'h0);
    chk("zero_after_p1", rd_a(1), 32'h0);

    // ---- Read-first and plain r0 (B) ----
    idle();
    wr_en_b = 1'b1; wr_dst_sel_b = 1'b1; wr_addr_rd_b = 4'd7; wr_addr_rt_b = 4'd2; wr_data_b = 16'h1111;
    tick();
    idle();
    wr_en_b = 1'b1; wr_dst_sel_b = 1'b1; wr_addr_rd_b = 4'd7; wr_addr_rt_b = 4'd2; wr_data_b = 16'h5678;
    rd_set_b(0, 4'd7); rd_set_b(1, 4'd7); rd_set_b(2, 4'd7);
    tick();
    chk("b_readfirst_p0", rd_b(0), 32'h1111);
    chk("b_readfirst_p1", rd_b(1), 32'h1111);
    chk("b_readfirst_p2", rd_b(2), 32'h1111);
    idle(); rd_set_b(0, 4'd7); rd_set_b(1, 4'd0); rd_set_b(2, 4'd2); tick();
    chk("b_new_r7", rd_b(0), 32'h5678);
    chk("b_r0_clear", rd_b(1), 32'h0);
    chk("b_r2_untouched", rd_b(2), 32'h0);
    idle();
    wr_en_b = 1'b1; wr_dst_sel_b = 1'b0; wr_addr_rt_b = 4'd0; wr_addr_rd_b = 4'd7; wr_data_b = 16'hFFFF;
    rd_set_b(1, 4'd0);
    tick();
    chk("b_r0_old", rd_b(1), 32'h0);
    chk("b_hold_p0", rd_b(0), 32'h5678);
    idle(); rd_set_b(2, 4'd0); rd_set_b(0, 4'd7); tick();
    chk("b_r0_written", rd_b(2), 32'hFFFF);
    chk("b_r7_kept", rd_b(0), 32'h5678);

    // ---- Reset mid-operation, then again mid-clear ----
    idle(); wr_a(5'd1, 32'h01010101); tick();
    idle(); wr_a(5'd2, 32'h02020202); tick();
    idle(); wr_a(5'd3, 32'h03030303); tick();
    idle(); wr_a(5'd30, 32'hCAFEF00D); tick();
    idle(); rd_set_a(0, 5'd1); rd_set_a(1, 5'd3); tick();
    chk("fill_r1", rd_a(0), 32'h01010101);
    chk("fill_r3", rd_a(1), 32'h03030303);
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    chk("rst_run_ready", {31'b0, ready}, 32'h0);
    chk("rst_run_rd0", rd_a(0), 32'h0);
    chk("rst_run_rd1", rd_a(1), 32'h0);
    for (int k = 0; k < 10; k++) begin
      idle();
      tick();
    end
    chk("midclear_ready", {31'b0, ready}, 32'h0);
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    n = 0;
    while (!ready && n < 200) begin
      idle();
      if (n == 3)  rd_set_a(0, 5'd30);
      if (n == 20) wr_a(5'd1, 32'h77777777);
      tick();
      if (n == 3) chk("clear_masks_read", rd_a(0), 32'h0);
      n++;
    end
    chk("reclear_len", n, 32);
    idle(); rd_set_a(0, 5'd1); rd_set_a(1, 5'd2); tick();
    chk("reclear_r1", rd_a(0), 32'h0);
    chk("reclear_r2", rd_a(1), 32'h0);
    idle(); rd_set_a(0, 5'd3); rd_set_a(1, 5'd30); tick();
    chk("reclear_r3", rd_a(0), 32'h0);
    chk("reclear_r30", rd_a(1), 32'h0);

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
